qerv_lsu_seq: RTL and testbench



---
 rtl/qerv_lsu_seq.sv | 199 +++++++++++++++++++
 tb/tb_qerv_lsu_seq.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qerv_lsu_seq.sv
// qerv_lsu_seq: load/store sequencer for the bit-serial core.
// It steps the shared data buffer through its store shift-in phase (INIT)
// and its load shift-out phase (RUN). In between it runs one Wishbone
// transfer. It also decodes byte selects and catches misaligned accesses
// before any bus cycle starts.
module qerv_lsu_seq #(
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_mem_req,
    input  logic       i_mem_we,
    input  logic [1:0] i_mem_size,
    input  logic [1:0] i_lsb,
    output logic       o_en,
    output logic       o_init,
    output logic [4:0] o_cnt,
    output logic       o_cnt_done,
    output logic       o_byte_valid,
    output logic       o_load,
    output logic       o_wb_cyc,
    output logic       o_wb_we,
    output logic [3:0] o_wb_sel,
    input  logic       i_wb_ack,
    output logic       o_misalign,
    output logic       o_mem_done
);

    // Width of the sub-step field inside the bit counter.
    // The low LB bits of o_cnt are always zero.
    localparam int LB = $clog2(BITS_PER_CYCLE);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_BUS  = 3'd2,
        ST_RUN  = 3'd3,
        ST_HOLD = 3'd4
    } state_t;

    state_t     state_r;
    logic [4:0] cnt_r;
    logic       wb_cyc_r;
    logic       wb_we_r;
    logic [3:0] wb_sel_r;

    logic       cnt_last_s;
    logic       active_s;
    logic       misalign_s;
    logic       ack_s;

    // A half access is misaligned when it is on an odd address.
    // A word access (size 2 or 3) is misaligned when it is not on a word boundary.
    function automatic logic misaligned_fn(input logic [1:0] size, input logic [1:0] lsb);
        logic res;
        case (size)
            2'd0:    res = 1'b0;
            2'd1:    res = lsb[0];
            default: res = (lsb != 2'd0);
        endcase
        return res;
    endfunction

    // Byte lanes that the access touches on the 32-bit bus.
    function automatic logic [3:0] sel_fn(input logic [1:0] size, input logic [1:0] lsb);
        logic [3:0] res;
        case (size)
            2'd0:    res = 4'b0001 << lsb;
            2'd1:    res = 4'b0011 << lsb;
            default: res = 4'b1111;
        endcase
        return res;
    endfunction

    // Number of bytes the access carries (1, 2 or 4).
    function automatic logic [2:0] size_bytes_fn(input logic [1:0] size);
        logic [2:0] res;
        case (size)
            2'd0:    res = 3'd1;
            2'd1:    res = 3'd2;
            default: res = 3'd4;
        endcase
        return res;
    endfunction

    // The counter only holds multiples of BITS_PER_CYCLE. So "all upper bits
    // set" is the same test as "last step of the 32-bit phase".
    assign cnt_last_s = &cnt_r[4:LB];
    assign active_s   = (state_r == ST_INIT) || (state_r == ST_RUN);
    // Reset suppresses these pulses. A reset that arrives together with a
    // request or an ack must not report a completion.
    assign misalign_s = (state_r == ST_IDLE) && i_mem_req && !i_rst
                        && misaligned_fn(i_mem_size, i_lsb);
    assign ack_s      = (state_r == ST_BUS) && i_wb_ack && !i_rst;

    // Sequencer state, bit counter and the registered bus-control outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 5'd0;
            wb_cyc_r <= 1'b0;
            wb_we_r  <= 1'b0;
            wb_sel_r <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= 5'd0;
                    if (i_mem_req) begin
                        if (misaligned_fn(i_mem_size, i_lsb)) begin
                            state_r <= ST_HOLD;
                        end else if (i_mem_we) begin
                            state_r <= ST_INIT;
                        end else begin
                            state_r  <= ST_BUS;
                            wb_cyc_r <= 1'b1;
                            wb_we_r  <= 1'b0;
                            wb_sel_r <= sel_fn(i_mem_size, i_lsb);
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_INIT: begin
                    if (cnt_last_s) begin
                        cnt_r    <= 5'd0;
                        state_r  <= ST_BUS;
                        wb_cyc_r <= 1'b1;
                        wb_we_r  <= i_mem_we;
                        wb_sel_r <= sel_fn(i_mem_size, i_lsb);
                    end else begin
                        cnt_r <= cnt_r + 5'(BITS_PER_CYCLE);
                    end
                end
                ST_BUS: begin
                    cnt_r <= 5'd0;
                    if (i_wb_ack) begin
                        wb_cyc_r <= 1'b0;
                        wb_we_r  <= 1'b0;
                        wb_sel_r <= 4'd0;
                        state_r  <= i_mem_we ? ST_HOLD : ST_RUN;
                    end else begin
                        state_r <= ST_BUS;
                    end
                end
                ST_RUN: begin
                    if (cnt_last_s) begin
                        cnt_r   <= 5'd0;
                        state_r <= ST_HOLD;
                    end else begin
                        cnt_r <= cnt_r + 5'(BITS_PER_CYCLE);
                    end
                end
                ST_HOLD: begin
                    cnt_r   <= 5'd0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    cnt_r    <= 5'd0;
                    state_r  <= ST_IDLE;
                    wb_cyc_r <= 1'b0;
                    wb_we_r  <= 1'b0;
                    wb_sel_r <= 4'd0;
                end
            endcase
        end
    end

    // Decode the buffer-register controls and the completion pulses.
    // Inputs: current state, counter and the request inputs.
    always_comb begin
        o_en         = active_s;
        o_init       = (state_r == ST_INIT);
        o_cnt_done   = active_s && cnt_last_s;
        o_byte_valid = 1'b0;
        o_load       = ack_s && !i_mem_we;
        o_misalign   = misalign_s;
        o_mem_done   = misalign_s || (ack_s && i_mem_we);
        case (state_r)
            // Shift-in stops early so the store data lands at byte offset i_lsb.
            ST_INIT: o_byte_valid = (({1'b0, cnt_r[4:3]} + {1'b0, i_lsb}) <= 3'd3);
            // Only the loaded bytes are emitted. The core extends the upper bytes.
            ST_RUN: begin
                o_byte_valid = ({1'b0, cnt_r[4:3]} < size_bytes_fn(i_mem_size));
                if (cnt_last_s && !i_rst) begin
                    o_mem_done = 1'b1;
                end else begin
                    o_mem_done = 1'b0;
                end
            end
            default: o_byte_valid = 1'b0;
        endcase
    end

    assign o_cnt    = cnt_r;
    assign o_wb_cyc = wb_cyc_r;
    assign o_wb_we  = wb_we_r;
    assign o_wb_sel = wb_sel_r;

endmodule

// File: tb/tb_qerv_lsu_seq.sv
// Bench for qerv_lsu_seq. Two instances: BITS_PER_CYCLE=4 (index 0) and
// BITS_PER_CYCLE=1 (index 1). Expected per-cycle outputs come from a
// transaction-level model that works out the phase lengths, byte lanes and
// pulse positions with plain arithmetic.
module tb_qerv_lsu_seq;

    logic       clk;
    logic       rst  [2];
    logic       req  [2];
    logic       we   [2];
    logic [1:0] size [2];
    logic [1:0] lsb  [2];
    logic       ack  [2];
    logic       en   [2];
    logic       init [2];
    logic [4:0] cnt  [2];
    logic       cdone[2];
    logic       bv   [2];
    logic       load [2];
    logic       cyc  [2];
    logic       wbwe [2];
    logic [3:0] sel  [2];
    logic       mis  [2];
    logic       done [2];

    int n_tests = 0;
    int n_fail  = 0;
    int bpc_of[2] = '{4, 1};

    typedef struct {
        logic       req, ack;
        logic       en, init;
        logic [4:0] cnt;
        logic       cdone, bv, load, cyc, wbwe;
        logic [3:0] sel;
        logic       mis, done;
    } exp_t;

    typedef struct {
        int         dut;
        logic       we;
        logic [1:0] size, lsb;
        int         delay;
        logic [3:0] exp_sel;
        int         exp_done;
    } vec_t;

    exp_t trace_q[$];

    qerv_lsu_seq #(.BITS_PER_CYCLE(4)) u_dut4 (
        .i_clk(clk), .i_rst(rst[0]), .i_mem_req(req[0]), .i_mem_we(we[0]),
        .i_mem_size(size[0]), .i_lsb(lsb[0]), .o_en(en[0]), .o_init(init[0]),
        .o_cnt(cnt[0]), .o_cnt_done(cdone[0]), .o_byte_valid(bv[0]),
        .o_load(load[0]), .o_wb_cyc(cyc[0]), .o_wb_we(wbwe[0]),
        .o_wb_sel(sel[0]), .i_wb_ack(ack[0]), .o_misalign(mis[0]),
        .o_mem_done(done[0])
    );

    qerv_lsu_seq #(.BITS_PER_CYCLE(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst[1]), .i_mem_req(req[1]), .i_mem_we(we[1]),
        .i_mem_size(size[1]), .i_lsb(lsb[1]), .o_en(en[1]), .o_init(init[1]),
        .o_cnt(cnt[1]), .o_cnt_done(cdone[1]), .o_byte_valid(bv[1]),
        .o_load(load[1]), .o_wb_cyc(cyc[1]), .o_wb_we(wbwe[1]),
        .o_wb_sel(sel[1]), .i_wb_ack(ack[1]), .o_misalign(mis[1]),
        .o_mem_done(done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] pack_act(input int d);
        return {en[d], init[d], cnt[d], cdone[d], bv[d], load[d], cyc[d],
                wbwe[d], sel[d], mis[d], done[d]};
    endfunction

    function automatic logic [17:0] pack_exp(input exp_t e);
        return {e.en, e.init, e.cnt, e.cdone, e.bv, e.load, e.cyc, e.wbwe,
                e.sel, e.mis, e.done};
    endfunction

    function automatic exp_t zero_exp();
        exp_t e;
        e = '{req: 1'b0, ack: 1'b0, en: 1'b0, init: 1'b0, cnt: 5'd0,
              cdone: 1'b0, bv: 1'b0, load: 1'b0, cyc: 1'b0, wbwe: 1'b0,
              sel: 4'd0, mis: 1'b0, done: 1'b0};
        return e;
    endfunction

    // Transaction model: the whole op as a list of per-cycle expectations.
    // Entry 0 is the IDLE cycle that sees the request. The last entry is HOLD.
    // With noise set, ack is toggled randomly in cycles where the design
    // must ignore it.
    task automatic build_trace(input int bpc, input logic we_i, input logic [1:0] size_i,
                               input logic [1:0] lsb_i, input int delay,
                               input bit keep, input bit noise);
        exp_t e;
        int nb, steps, pos;
        logic [3:0] sel_m;
        trace_q.delete();
        nb    = (size_i == 2'd0) ? 1 : (size_i == 2'd1) ? 2 : 4;
        steps = 32 / bpc;
        sel_m = 4'd0;
        for (int b = 0; b < 4; b++) begin
            if (b >= int'(lsb_i) && b < int'(lsb_i) + nb) sel_m[b] = 1'b1;
        end
        e = zero_exp();
        e.req = 1'b1;
        e.ack = noise ? 1'($urandom) : 1'b0;
        if ((int'(lsb_i) % nb) != 0) begin
            e.mis  = 1'b1;
            e.done = 1'b1;
            trace_q.push_back(e);
        end else begin
            trace_q.push_back(e);
            if (we_i) begin
                for (int k = 0; k < steps; k++) begin
                    pos = k * bpc;
                    e = zero_exp();
                    e.req = 1'b1; e.ack = noise ? 1'($urandom) : 1'b0;
                    e.en = 1'b1; e.init = 1'b1; e.cnt = 5'(pos);
                    e.cdone = (k == steps - 1);
                    e.bv = (pos / 8 + int'(lsb_i)) <= 3;
                    trace_q.push_back(e);
                end
            end
            for (int j = 0; j <= delay; j++) begin
                e = zero_exp();
                e.req = 1'b1; e.ack = (j == delay);
                e.cyc = 1'b1; e.wbwe = we_i; e.sel = sel_m;
                e.done = e.ack && we_i;
                e.load = e.ack && !we_i;
                trace_q.push_back(e);
            end
            if (!we_i) begin
                for (int k = 0; k < steps; k++) begin
                    pos = k * bpc;
                    e = zero_exp();
                    e.req = 1'b1; e.ack = noise ? 1'($urandom) : 1'b0;
                    e.en = 1'b1; e.cnt = 5'(pos);
                    e.cdone = (k == steps - 1);
                    e.bv = (pos / 8) < nb;
                    e.done = (k == steps - 1);
                    trace_q.push_back(e);
                end
            end
        end
        e = zero_exp();
        e.req = keep;
        e.ack = noise ? 1'($urandom) : 1'b0;
        trace_q.push_back(e);
    endtask

    task automatic check(input string name, input int cyc_i, input logic [17:0] got,
                         input logic [17:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %05h want %05h", name, cyc_i, got, want);
        end
    endtask

    // Drive the current trace into DUT d and compare every cycle.
    task automatic apply(input int d, input string name, input logic we_i,
                         input logic [1:0] size_i, input logic [1:0] lsb_i,
                         output int done_at, output logic [3:0] sel_seen);
        done_at  = -1;
        sel_seen = 4'd0;
        for (int i = 0; i < trace_q.size(); i++) begin
            @(negedge clk);
            if (i == 0) begin
                we[d] = we_i; size[d] = size_i; lsb[d] = lsb_i;
            end
            req[d] = trace_q[i].req;
            ack[d] = trace_q[i].ack;
            #1;
            check(name, i, pack_act(d), pack_exp(trace_q[i]));
            if (done[d] && done_at < 0) done_at = i;
            if (cyc[d]) sel_seen = sel[d];
        end
        ack[d] = 1'b0;
    endtask

    task automatic run_op(input int d, input string name, input logic we_i,
                          input logic [1:0] size_i, input logic [1:0] lsb_i,
                          input int delay, input bit keep, input bit noise);
        int da;
        logic [3:0] ss;
        build_trace(bpc_of[d], we_i, size_i, lsb_i, delay, keep, noise);
        apply(d, name, we_i, size_i, lsb_i, da, ss);
    endtask

    vec_t vecs[10];

    initial begin
        int da;
        logic [3:0] ss;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req[d] = 1'b0; we[d] = 1'b0;
            size[d] = 2'd0; lsb[d] = 2'd0; ack[d] = 1'b0;
        end

        // Directed table: op, expected byte selects, cycle index of o_mem_done.
        vecs[0] = '{0, 1'b1, 2'd2, 2'd0, 2, 4'hF, 11};  // word store
        vecs[1] = '{0, 1'b1, 2'd0, 2'd3, 0, 4'h8, 9};   // byte store lsb3
        vecs[2] = '{0, 1'b0, 2'd1, 2'd2, 0, 4'hC, 9};   // half load lsb2
        vecs[3] = '{0, 1'b0, 2'd2, 2'd1, 0, 4'h0, 0};   // misaligned word
        vecs[4] = '{0, 1'b1, 2'd1, 2'd1, 0, 4'h0, 0};   // misaligned half
        vecs[5] = '{0, 1'b0, 2'd0, 2'd1, 3, 4'h2, 12};  // byte load, slow ack
        vecs[6] = '{0, 1'b1, 2'd1, 2'd2, 1, 4'hC, 10};  // half store lsb2
        vecs[7] = '{0, 1'b0, 2'd3, 2'd0, 1, 4'hF, 10};  // size 3 as word
        vecs[8] = '{1, 1'b1, 2'd2, 2'd0, 0, 4'hF, 33};  // 1-bit word store
        vecs[9] = '{1, 1'b0, 2'd0, 2'd0, 1, 4'h1, 34};  // 1-bit byte load

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_dut4", 0, pack_act(0), 18'd0);
        check("reset_dut1", 0, pack_act(1), 18'd0);
        rst[0] = 1'b0; rst[1] = 1'b0;

        for (int v = 0; v < 10; v++) begin
            build_trace(bpc_of[vecs[v].dut], vecs[v].we, vecs[v].size, vecs[v].lsb,
                        vecs[v].delay, 1'b0, 1'b0);
            apply(vecs[v].dut, $sformatf("vec%0d", v), vecs[v].we, vecs[v].size,
                  vecs[v].lsb, da, ss);
            n_tests++;
            if (da != vecs[v].exp_done) begin
                n_fail++;
                $display("FAIL vec%0d_done_cycle: got %0d want %0d", v, da, vecs[v].exp_done);
            end
            n_tests++;
            if (ss !== vecs[v].exp_sel) begin
                n_fail++;
                $display("FAIL vec%0d_sel: got %h want %h", v, ss, vecs[v].exp_sel);
            end
        end

        // Reset in BUS together with ack: no load, then back to IDLE.
        @(negedge clk);
        we[0] = 1'b0; size[0] = 2'd2; lsb[0] = 2'd0; req[0] = 1'b1;
        @(negedge clk);
        #1;
        check("rst_bus_cyc", 0, {17'd0, cyc[0]}, 18'd1);
        @(negedge clk);
        rst[0] = 1'b1; ack[0] = 1'b1;
        #1;
        check("rst_bus_pulses", 1, {16'd0, load[0], done[0]}, 18'd0);
        @(negedge clk);
        rst[0] = 1'b0; ack[0] = 1'b0; req[0] = 1'b0;
        #1;
        check("rst_bus_after", 2, pack_act(0), 18'd0);
        @(negedge clk);
        ack[0] = 1'b1;
        #1;
        check("late_ack_idle", 3, pack_act(0), 18'd0);
        ack[0] = 1'b0;
        run_op(0, "post_rst_load", 1'b0, 2'd2, 2'd0, 1, 1'b0, 1'b0);

        // Back-to-back: request held high through HOLD.
        run_op(0, "b2b_st", 1'b1, 2'd2, 2'd0, 0, 1'b1, 1'b0);
        run_op(0, "b2b_mis", 1'b0, 2'd2, 2'd2, 0, 1'b1, 1'b0);
        run_op(0, "b2b_ld", 1'b0, 2'd1, 2'd0, 2, 1'b0, 1'b0);
        run_op(1, "b2b1_st", 1'b1, 2'd2, 2'd0, 1, 1'b1, 1'b0);
        run_op(1, "b2b1_ld", 1'b0, 2'd2, 2'd0, 0, 1'b0, 1'b0);

        // Random ops with ack noise outside BUS.
        for (int r = 0; r < 60; r++) begin
            run_op(0, $sformatf("rnd4_%0d", r), 1'($urandom), 2'($urandom), 2'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom), 1'b1);
        end
        for (int r = 0; r < 12; r++) begin
            run_op(1, $sformatf("rnd1_%0d", r), 1'($urandom), 2'($urandom), 2'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom), 1'b1);
        end
        @(negedge clk);
        req[0] = 1'b0; req[1] = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
